// File: rtl/nibble_serial_cla_adder.sv
// Nibble-serial wide adder: one 4-bit carry-lookahead slice per clock, start/done handshake.
// Optional two's-complement overflow output enabled by defining NSCA_OVERFLOW_EN.
module nibble_serial_cla_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
`ifdef NSCA_OVERFLOW_EN
  output logic                   cout,
  output logic                   ovf
`else
  output logic                   cout
`endif
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cy;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_busy;
  logic            r_done;

  logic [3:0]      w_an;
  logic [3:0]      w_bn;
  logic [3:0]      w_g;
  logic [3:0]      w_p;
  logic [3:0]      w_c;
  logic            w_c4;
  logic [3:0]      w_s;
  logic            w_last;

  assign w_an   = r_a[{r_idx, 2'b00} +: 4];
  assign w_bn   = r_b[{r_idx, 2'b00} +: 4];
  assign w_last = (r_idx == IDXW'(NIBBLES - 1));

  // Full lookahead: every carry is a flat sum of products of g/p and the slice carry-in.
  always_comb begin
    w_g    = w_an & w_bn;
    w_p    = w_an ^ w_bn;
    w_c    = '0;
    w_c[0] = r_cy;
    w_c[1] = w_g[0] | (w_p[0] & r_cy);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_cy);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_cy);
    w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_cy);
    w_s    = w_p ^ w_c;
  end

`ifdef NSCA_OVERFLOW_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cy    <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef NSCA_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cy    <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef NSCA_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_s;
          r_cy <= w_c4;
          if (w_last) begin
            r_cout  <= w_c4;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef NSCA_OVERFLOW_EN
            r_ovf   <= w_c[3] ^ w_c4;
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef NSCA_OVERFLOW_EN
  assign ovf  = r_ovf;
`endif

endmodule
